// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
//
// Generates load enables, flushes and bubbles for the PC, IF_ID, ID_EX, EX_MEM
// and MEM_WB registers. Three hazard sources are resolved in fixed priority:
// data-memory wait, then taken-branch/jump redirect, then load-use. Also keeps
// saturating stall/redirect counters and a sticky memory-wait watchdog flag.
//
// Ports:
//   clk, Reset            clock (rising edge), asynchronous active-low reset
//   MemRead_ex, rdAddr_ex load in EX and its destination register
//   rs1Addr_id/rs2Addr_id source registers of the ID instruction
//   rs1Used_id/rs2Used_id ID instruction actually reads rs1/rs2
//   Branch_taken_ex       EX resolves a taken branch or jump
//   MemAccess_mem         MEM stage has an active load/store
//   mem_ready             data memory completes the access this cycle
//   cnt_clr               synchronous clear of stall_cnt and flush_cnt
//   PC_write .. MEM_WB_bubble  pipeline register controls (combinational)
//   stall_cnt, flush_cnt  saturating performance counters
//   mem_timeout           sticky watchdog flag
//   state_o               current state (RUN=0, MWAIT=1, REDIR=2)
module hazard_ctrl #(
    parameter int unsigned REDIRECT_BUBBLES = 2,
    parameter int unsigned TIMEOUT          = 255,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             MemRead_ex,
    input  logic [4:0]       rdAddr_ex,
    input  logic [4:0]       rs1Addr_id,
    input  logic [4:0]       rs2Addr_id,
    input  logic             rs1Used_id,
    input  logic             rs2Used_id,
    input  logic             Branch_taken_ex,
    input  logic             MemAccess_mem,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write,
    output logic             MEM_WB_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StMwait = 2'd1,
        StRedir = 2'd2
    } state_e;

    localparam int unsigned      WaitW     = $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax   = WaitW'(TIMEOUT);
    localparam logic [1:0]       RedirLoad = 2'(REDIRECT_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [1:0]       redir_cnt_q, redir_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic mstall;
    logic lu;
    logic redirect;
    logic lu_stall;

    // Hazard terms are gated by Reset so that the outputs fall back to their
    // no-hazard values as soon as reset asserts, without waiting for an edge.
    always_comb begin
        mstall = Reset & MemAccess_mem & ~mem_ready;
        lu     = Reset & MemRead_ex & (rdAddr_ex != 5'd0) &
                 ((rs1Used_id & (rs1Addr_id == rdAddr_ex)) |
                  (rs2Used_id & (rs2Addr_id == rdAddr_ex)));
    end

    // Next-state and control outputs
    always_comb begin
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_write   = 1'b1;
        ID_EX_flush   = 1'b0;
        EX_MEM_write  = 1'b1;
        MEM_WB_bubble = 1'b0;
        state_d       = state_q;
        redir_cnt_d   = redir_cnt_q;
        redirect      = 1'b0;
        lu_stall      = 1'b0;

        if (mstall) begin
            // Freeze everything up to EX_MEM; redir_cnt is held.
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_write  = 1'b0;
            MEM_WB_bubble = 1'b1;
            state_d       = StMwait;
        end else if (Reset) begin
            case (state_q)
                StRedir: begin
                    // EX and ID hold bubbles here, so branch and lu are ignored.
                    IF_ID_flush = 1'b1;
                    if (redir_cnt_q <= 2'd1) begin
                        redir_cnt_d = 2'd0;
                        state_d     = StRun;
                    end else begin
                        redir_cnt_d = redir_cnt_q - 2'd1;
                        state_d     = StRedir;
                    end
                end
                default: begin
                    // StRun, or StMwait leaving because the access completed.
                    if (Branch_taken_ex) begin
                        redirect    = 1'b1;
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                        redir_cnt_d = RedirLoad;
                        state_d     = (RedirLoad != 2'd0) ? StRedir : StRun;
                    end else if (redir_cnt_q != 2'd0) begin
                        // Memory wait interrupted a redirect: finish its bubbles.
                        state_d = StRedir;
                    end else if (lu) begin
                        lu_stall    = 1'b1;
                        PC_write    = 1'b0;
                        IF_ID_write = 1'b0;
                        ID_EX_flush = 1'b1;
                        state_d     = StRun;
                    end else begin
                        state_d = StRun;
                    end
                end
            endcase
        end
    end

    // Counters and watchdog
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if ((mstall | lu_stall) && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        if (cnt_clr) begin
            flush_cnt_d = '0;
        end else if (redirect && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end

        if (!mstall) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        mem_timeout_d = mem_timeout_q | (mstall & (wait_cnt_d == WaitMax));
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= StRun;
            redir_cnt_q   <= 2'd0;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            redir_cnt_q   <= redir_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign mem_timeout = mem_timeout_q;
    assign state_o     = state_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives write-enable, flush and bubble controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB. The ID_EX register gains a write enable (ID_EX_write) and a synchronous flush.
- Resolves three hazard sources in fixed priority:
  1. data-memory wait, highest
  2. taken-branch/jump redirect
  3. load-use, lowest
- Provides saturating stall/flush counters and a memory-wait watchdog.

Parameters:
- REDIRECT_BUBBLES, 2: IF_ID flush cycles per redirect, including the redirect cycle; range 1..4.
- TIMEOUT, 255: consecutive mem-wait cycles that set mem_timeout; minimum 1.
- CNT_W, 16: width of the performance counters.

Ports:
- clk in 1: core clock, rising edge.
- Reset in 1: asynchronous, active-low reset.
- MemRead_ex in 1: instruction in EX is a load.
- rdAddr_ex in 5: destination register of the EX instruction.
- rs1Addr_id in 5: rs1 of the ID instruction.
- rs2Addr_id in 5: rs2 of the ID instruction.
- rs1Used_id in 1: ID instruction reads rs1.
- rs2Used_id in 1: ID instruction reads rs2.
- Branch_taken_ex in 1: EX resolves a taken branch or jump.
- MemAccess_mem in 1: MEM stage has an active load or store.
- mem_ready in 1: data memory completes the access this cycle.
- cnt_clr in 1: synchronous clear of both counters.
- PC_write out 1: PC load enable.
- IF_ID_write out 1: IF_ID load enable.
- IF_ID_flush out 1: IF_ID loads a NOP.
- ID_EX_write out 1: ID_EX load enable.
- ID_EX_flush out 1: ID_EX loads zero controls (bubble).
- EX_MEM_write out 1: EX_MEM load enable.
- MEM_WB_bubble out 1: MEM_WB loads zero controls.
- stall_cnt out CNT_W: saturating count of stall cycles.
- flush_cnt out CNT_W: saturating count of redirect events.
- mem_timeout out 1: sticky watchdog flag.
- state_o out 2: current state; RUN=0, MWAIT=1, REDIR=2.

Behaviour:
- All control outputs are combinational from the state register, redir_cnt and the inputs. They take effect on the same clock edge, with zero added latency.
- Reset (Reset=0, any time, including mid-wait):
  - state=RUN, redir_cnt=0, wait_cnt=0.
  - stall_cnt=0, flush_cnt=0, mem_timeout=0.
  - Outputs settle to the RUN/no-hazard values: all *_write=1, all flush/bubble signals=0.
- Derived terms:
  - mstall = MemAccess_mem & ~mem_ready.
  - lu = MemRead_ex & (rdAddr_ex!=0) & ((rs1Used_id & rs1Addr_id==rdAddr_ex) | (rs2Used_id & rs2Addr_id==rdAddr_ex)).
- Priority 1, mstall (any state):
  - PC_write, IF_ID_write, ID_EX_write and EX_MEM_write all 0; MEM_WB_bubble=1.
  - All flushes 0.
  - Next state = MWAIT; redir_cnt is frozen.
- Priority 2, Branch_taken_ex in RUN or MWAIT:
  - IF_ID_flush=1, ID_EX_flush=1, PC_write=1.
  - flush_cnt increments.
  - redir_cnt loads REDIRECT_BUBBLES-1. Next state = REDIR if that value is nonzero, else RUN.
  - lu is ignored.
- REDIR state without mstall:
  - IF_ID_flush=1, PC_write=1.
  - redir_cnt decrements; go to RUN when it reaches 0.
  - Branch_taken_ex and lu are ignored, because EX and ID hold bubbles.
- Priority 3, lu in RUN:
  - PC_write=0, IF_ID_write=0, ID_EX_flush=1.
  - State stays RUN.
  - Exactly one bubble per load-use pair.
- MWAIT exit when mstall drops: go to REDIR if redir_cnt!=0, else RUN. Priorities 2 and 3 are evaluated in that same cycle.
- wait_cnt:
  - Increments every mstall cycle and saturates at TIMEOUT.
  - Clears on any cycle without mstall.
  - mem_timeout is set when wait_cnt reaches TIMEOUT and stays set until Reset.
- stall_cnt increments on mstall or an applied lu stall. flush_cnt increments on an applied redirect.
- Both counters saturate at 2^CNT_W-1. cnt_clr has priority over increment.

Test Plan:
- Load-use: MemRead_ex=1, rdAddr_ex=5, rs2Addr_id=5, rs2Used_id=1 for one cycle → PC_write=0, IF_ID_write=0, ID_EX_flush=1 for exactly 1 cycle; stall_cnt=1. Repeat with rdAddr_ex=0 → no stall.
- Redirect with REDIRECT_BUBBLES=2: Branch_taken_ex pulse →
  - cycle 0: IF_ID_flush=1, ID_EX_flush=1.
  - cycle 1: IF_ID_flush=1, state=REDIR.
  - cycle 2: RUN, no flushes; flush_cnt=1.
  - lu asserted in cycle 1 is ignored.
- Memory wait: MemAccess_mem=1, mem_ready=0 for 3 cycles, then 1 → all *_write=0 and MEM_WB_bubble=1 for 3 cycles, state=MWAIT, stall_cnt=3, then RUN.
- Simultaneous events:
  - mstall, Branch_taken_ex and lu together → only the memory-stall controls are driven.
  - When mstall clears, the redirect is applied in that cycle.
- Watchdog with TIMEOUT=4: mstall held 6 cycles → mem_timeout rises after the 4th wait cycle and stays 1 after mem_ready. Counters saturate with CNT_W=2 (value 3).
- Reset asserted mid-REDIR and mid-MWAIT → immediate state=RUN, counters 0, outputs at default without waiting for a clock edge. cnt_clr together with an increment event → counter reads 0.
